instr_load_arbiter: RTL and testbench
=====================================

# instr_load_arbiter

Front-end controller for the 32-entry instruction register. It shares the register's single write port between two requesters using round-robin arbitration, and allocates write addresses sequentially while tracking occupancy. On command it drains the loaded entries by stepping the read pointer through them under a valid/ready handshake. It sits between the stimulus/requester agents and the instruction register's load_en, write_pointer, opcode, operand and read_pointer inputs.

## Interface
- DEPTH, 32, number of register entries; write and read addresses wrap within 0..DEPTH-1
- ADDR_W, 5, width of write_pointer and read_pointer; DEPTH = 2**ADDR_W
- OPC_W, 4, opcode width
- OPR_W, 32, operand width (signed)
- clk  in  1  single clock; all state updates on the rising edge
- reset_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk
- req_valid  in  2  per-requester load request
- req_ready  out  2  per-requester grant (combinational); bit i accepts when req_valid[i] & req_ready[i]
- req_opcode  in  2*OPC_W  opcode per requester; bits [OPC_W*i +: OPC_W] belong to requester i
- req_operand_a  in  2*OPR_W  operand_a per requester, same packing
- req_operand_b  in  2*OPR_W  operand_b per requester, same packing
- load_en  out  1  write strobe to the instruction register (registered)
- write_pointer  out  ADDR_W  write address (registered)
- opcode  out  OPC_W  opcode to write (registered)
- operand_a  out  OPR_W  operand_a to write (registered)
- operand_b  out  OPR_W  operand_b to write (registered)
- drain_start  in  1  request to read out all loaded entries
- read_pointer  out  ADDR_W  read address to the instruction register (registered)
- rd_valid  out  1  the register output at read_pointer is a valid drained entry
- rd_ready  in  1  consumer accepts the current entry
- drain_done  out  1  one-cycle pulse after the last entry is accepted
- count  out  ADDR_W+1  number of loaded entries, 0..DEPTH
- full  out  1  count == DEPTH
- busy  out  1  FSM is in DRAIN

## Operation
- FSM states are FILL (the reset state) and DRAIN.
- FILL arbitration:
  - Requests are eligible only when not full and drain_start is low.
  - With one requester valid, that requester is granted.
  - With both valid, the requester that was not granted most recently is granted.
  - The priority pointer resets to favour requester 0. It toggles only on an accepted transfer.
  - At most one grant per cycle. req_ready is 0 in DRAIN, when full, and during reset.
- Accept:
  - On the next edge, load_en=1, write_pointer=wp, and opcode/operand_a/operand_b take the granted requester's fields.
  - On the same edge, wp increments modulo DEPTH and count increments.
  - With no accept, load_en=0 and the data outputs hold.
- drain_start in FILL:
  - With count>0, the FSM enters DRAIN on the next edge with read_pointer=0 and rd_valid=1.
  - With count==0, drain_start is ignored and drain_done is not pulsed.
  - drain_start has priority over requests in the same cycle; no grant is issued that cycle.
- DRAIN:
  - rd_valid stays 1, with idx on read_pointer.
  - When rd_ready is high and idx < count-1, idx increments.
  - When rd_ready is high and idx == count-1, on that edge: FSM returns to FILL, rd_valid=0, read_pointer=0, count=0, wp=0, and drain_done=1 for exactly one cycle.
  - rd_ready low stalls; read_pointer holds.
- Contents of the instruction register are not cleared by a drain. The next load overwrites from address 0.
- Reset (reset_n low at an edge, including mid-drain or mid-load):
  - All outputs go to 0: load_en, write_pointer, opcode, operand_a, operand_b, read_pointer, rd_valid, drain_done, count, full, busy, and req_ready (req_ready held 0 while reset_n is low).
  - The FSM goes to FILL and the priority pointer resets to favour requester 0.
  - A request pending at reset is not accepted.

## Timing
- Accept to load_en: 1 cycle. Sustained throughput is 1 load per cycle.
- count and full update on the accept edge. A requester sees req_ready drop in the cycle after the DEPTH-th accept.
- drain_start to first rd_valid: 1 cycle.
- The write issued by an accept in the cycle before drain_start completes on the same edge DRAIN is entered, so read data is consistent.
- Drain of N entries with rd_ready held high: N cycles of rd_valid, then drain_done on the edge after the final accept.
- wp wraps from DEPTH-1 to 0. This occurs only after a full drain, since full blocks a 33rd accept.

## Test plan
- Reset: hold reset_n low 2 cycles with both req_valid=1 -> all outputs 0, req_ready=00. After release, requester 0 is granted first.
- Round-robin: both requesters valid for 4 cycles -> grants 0,1,0,1. load_en rises 1 cycle after each accept with write_pointer 0,1,2,3 and each requester's opcode/operands. count=4.
- Fill to full: 32 accepts from requester 1 -> full=1, count=32, req_ready=00 on the next cycle, and a 33rd request is stalled.
- Drain with backpressure: load 3 entries, pulse drain_start, toggle rd_ready 1,0,1,1 -> read_pointer 0,1,1,2. drain_done pulses once. count=0, and the next load goes to address 0.
- Simultaneous events: drain_start and req_valid in the same cycle with count=2 -> no grant and DRAIN is entered. drain_start with count=0 -> stays in FILL, no drain_done.
- Reset mid-drain: assert reset_n low with read_pointer=5 -> next edge FILL, rd_valid=0, read_pointer=0, count=0.

Source files
------------

// File: rtl/instr_load_arbiter.sv
// -----------------------------------------------------------------------------
// instr_load_arbiter
//
// Front-end controller for a 32-entry instruction register. Two requesters
// share the register's single write port through a round-robin arbiter; write
// addresses are handed out sequentially and occupancy is tracked in count.
// On drain_start the loaded entries are read out in order by stepping
// read_pointer under a rd_valid/rd_ready handshake.
//
// Ports
//   clk, reset_n           clock, synchronous active-low reset
//   req_valid/req_ready    per-requester load handshake (req_ready is combinational)
//   req_opcode             packed opcodes, requester i at [OPC_W*i +: OPC_W]
//   req_operand_a/_b       packed signed operands, requester i at [OPR_W*i +: OPR_W]
//   load_en                registered write strobe to the instruction register
//   write_pointer          registered write address
//   opcode, operand_a/_b   registered write data
//   drain_start            request to read out every loaded entry
//   read_pointer           registered read address
//   rd_valid/rd_ready      drain handshake
//   drain_done             one-cycle pulse after the final drained entry
//   count, full, busy      occupancy, occupancy == DEPTH, FSM in DRAIN
// -----------------------------------------------------------------------------
module instr_load_arbiter #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5,
    parameter int OPC_W  = 4,
    parameter int OPR_W  = 32
) (
    input  logic                     clk,
    input  logic                     reset_n,

    input  logic [1:0]               req_valid,
    output logic [1:0]               req_ready,
    input  logic [2*OPC_W-1:0]       req_opcode,
    input  logic [2*OPR_W-1:0]       req_operand_a,
    input  logic [2*OPR_W-1:0]       req_operand_b,

    output logic                     load_en,
    output logic [ADDR_W-1:0]        write_pointer,
    output logic [OPC_W-1:0]         opcode,
    output logic signed [OPR_W-1:0]  operand_a,
    output logic signed [OPR_W-1:0]  operand_b,

    input  logic                     drain_start,
    output logic [ADDR_W-1:0]        read_pointer,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic                     drain_done,

    output logic [ADDR_W:0]          count,
    output logic                     full,
    output logic                     busy
);

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] CNT_DEPTH = (ADDR_W+1)'(DEPTH);

    state_t                     state;
    state_t                     state_nxt;

    logic [ADDR_W-1:0]          wp;
    // Index of the requester granted most recently; the other one wins a tie.
    logic                       last_grant;

    logic [1:0]                 grant;
    logic                       grant_sel;
    logic                       accept;
    logic                       drain_go;
    logic                       drain_last;
    logic                       last_entry;

    logic [OPC_W-1:0]           sel_opcode;
    logic signed [OPR_W-1:0]    sel_operand_a;
    logic signed [OPR_W-1:0]    sel_operand_b;

    assign full       = (count == CNT_DEPTH);
    assign busy       = (state == DRAIN);
    // count is at least 1 whenever the FSM is in DRAIN, so count-1 never underflows there.
    assign last_entry = ({1'b0, read_pointer} == (count - CNT_ONE));

    // -------------------------------------------------------------------------
    // Arbitration and next-state decode
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt  = state;
        grant      = 2'b00;
        grant_sel  = 1'b0;
        drain_go   = 1'b0;
        drain_last = 1'b0;

        case (state)
            FILL: begin
                // drain_start takes precedence over any load request this cycle.
                if (drain_start) begin
                    if (count != '0) begin
                        drain_go  = 1'b1;
                        state_nxt = DRAIN;
                    end
                end else if (!full) begin
                    if (req_valid == 2'b11) begin
                        grant_sel = ~last_grant;
                    end else begin
                        grant_sel = req_valid[1];
                    end
                    if (req_valid != 2'b00) begin
                        grant = grant_sel ? 2'b10 : 2'b01;
                    end
                end
            end
            DRAIN: begin
                if (rd_ready && last_entry) begin
                    drain_last = 1'b1;
                    state_nxt  = FILL;
                end
            end
            default: begin
                state_nxt = FILL;
            end
        endcase

        // No grant may be observed while reset is being applied.
        if (!reset_n) begin
            grant = 2'b00;
        end
    end

    assign req_ready = grant;
    assign accept    = |grant;

    always_comb begin
        sel_opcode    = grant_sel ? req_opcode[OPC_W +: OPC_W]
                                  : req_opcode[0 +: OPC_W];
        sel_operand_a = grant_sel ? $signed(req_operand_a[OPR_W +: OPR_W])
                                  : $signed(req_operand_a[0 +: OPR_W]);
        sel_operand_b = grant_sel ? $signed(req_operand_b[OPR_W +: OPR_W])
                                  : $signed(req_operand_b[0 +: OPR_W]);
    end

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Write-side registers: strobe, address, data, allocation and occupancy
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            load_en       <= 1'b0;
            write_pointer <= '0;
            opcode        <= '0;
            operand_a     <= '0;
            operand_b     <= '0;
            wp            <= '0;
            count         <= '0;
            last_grant    <= 1'b1;
        end else begin
            load_en <= accept;
            if (accept) begin
                write_pointer <= wp;
                opcode        <= sel_opcode;
                operand_a     <= sel_operand_a;
                operand_b     <= sel_operand_b;
                // wp is ADDR_W bits wide and DEPTH == 2**ADDR_W, so it wraps naturally.
                wp            <= wp + 1'b1;
                count         <= count + CNT_ONE;
                last_grant    <= grant_sel;
            end else if (drain_last) begin
                // A completed drain frees every entry; the next load restarts at 0.
                wp    <= '0;
                count <= '0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Read-side registers: drain pointer and handshake
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            read_pointer <= '0;
            rd_valid     <= 1'b0;
            drain_done   <= 1'b0;
        end else begin
            drain_done <= 1'b0;
            if (drain_go) begin
                read_pointer <= '0;
                rd_valid     <= 1'b1;
            end else if (drain_last) begin
                read_pointer <= '0;
                rd_valid     <= 1'b0;
                drain_done   <= 1'b1;
            end else if (busy && rd_ready) begin
                read_pointer <= read_pointer + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instr_load_arbiter.sv
// -----------------------------------------------------------------------------
// tb_instr_load_arbiter
//
// Directed scenarios followed by a randomized phase. A behavioural model
// (occupancy counter, drain index and last-granted requester) predicts the
// combinational grants before each edge and every registered output after it.
// -----------------------------------------------------------------------------
module tb_instr_load_arbiter;

    localparam int DEPTH  = 32;
    localparam int ADDR_W = 5;
    localparam int OPC_W  = 4;
    localparam int OPR_W  = 32;

    logic                     clk = 1'b0;
    logic                     reset_n;
    logic [1:0]               req_valid;
    logic [1:0]               req_ready;
    logic [2*OPC_W-1:0]       req_opcode;
    logic [2*OPR_W-1:0]       req_operand_a;
    logic [2*OPR_W-1:0]       req_operand_b;
    logic                     load_en;
    logic [ADDR_W-1:0]        write_pointer;
    logic [OPC_W-1:0]         opcode;
    logic signed [OPR_W-1:0]  operand_a;
    logic signed [OPR_W-1:0]  operand_b;
    logic                     drain_start;
    logic [ADDR_W-1:0]        read_pointer;
    logic                     rd_valid;
    logic                     rd_ready;
    logic                     drain_done;
    logic [ADDR_W:0]          count;
    logic                     full;
    logic                     busy;

    always #5 clk = ~clk;

    instr_load_arbiter #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W),
        .OPC_W (OPC_W),
        .OPR_W (OPR_W)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_opcode   (req_opcode),
        .req_operand_a(req_operand_a),
        .req_operand_b(req_operand_b),
        .load_en      (load_en),
        .write_pointer(write_pointer),
        .opcode       (opcode),
        .operand_a    (operand_a),
        .operand_b    (operand_b),
        .drain_start  (drain_start),
        .read_pointer (read_pointer),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .drain_done   (drain_done),
        .count        (count),
        .full         (full),
        .busy         (busy)
    );

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model state
    int  m_cnt  = 0;      // number of loaded entries
    int  m_last = 1;      // requester granted most recently (1 => favour 0)
    bit  m_drain = 0;     // draining
    int  m_idx  = 0;      // entry currently offered on the read side

    // Expected registered outputs
    logic                     e_load_en = 0;
    logic [ADDR_W-1:0]        e_wp      = 0;
    logic [OPC_W-1:0]         e_opc     = 0;
    logic signed [OPR_W-1:0]  e_opa     = 0;
    logic signed [OPR_W-1:0]  e_opb     = 0;
    logic                     e_rdv     = 0;
    logic                     e_done    = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic new_data();
        req_opcode    = OPC_W'($urandom) | (2*OPC_W)'({OPC_W'($urandom), {OPC_W{1'b0}}});
        req_operand_a = {$urandom, $urandom};
        req_operand_b = {$urandom, $urandom};
    endtask

    // One clock: check grants, advance model at the edge, check registered outputs.
    task automatic cycle();
        int         gi;
        logic [1:0] exp_ready;
        #1;
        gi = -1;
        exp_ready = 2'b00;
        if (reset_n && !m_drain && m_cnt < DEPTH && !drain_start) begin
            if (req_valid == 2'b11)  gi = (m_last == 0) ? 1 : 0;
            else if (req_valid[0])   gi = 0;
            else if (req_valid[1])   gi = 1;
        end
        if (gi >= 0) exp_ready[gi] = 1'b1;
        check("req_ready", 64'(req_ready), 64'(exp_ready));

        @(posedge clk);
        e_load_en = 0;
        e_done    = 0;
        if (!reset_n) begin
            m_cnt = 0; m_last = 1; m_drain = 0; m_idx = 0;
            e_wp = 0; e_opc = 0; e_opa = 0; e_opb = 0; e_rdv = 0;
        end else if (m_drain) begin
            if (rd_ready) begin
                if (m_idx == m_cnt - 1) begin
                    m_drain = 0; m_idx = 0; m_cnt = 0; e_rdv = 0; e_done = 1;
                end else begin
                    m_idx++;
                end
            end
        end else if (drain_start) begin
            if (m_cnt > 0) begin
                m_drain = 1; m_idx = 0; e_rdv = 1;
            end
        end else if (gi >= 0) begin
            e_load_en = 1;
            e_wp  = ADDR_W'(m_cnt % DEPTH);
            e_opc = req_opcode[gi*OPC_W +: OPC_W];
            e_opa = req_operand_a[gi*OPR_W +: OPR_W];
            e_opb = req_operand_b[gi*OPR_W +: OPR_W];
            m_cnt++;
            m_last = gi;
        end

        #1;
        check("load_en",       64'(load_en),       64'(e_load_en));
        check("write_pointer", 64'(write_pointer), 64'(e_wp));
        check("opcode",        64'(opcode),        64'(e_opc));
        check("operand_a",     64'(operand_a),     64'(e_opa));
        check("operand_b",     64'(operand_b),     64'(e_opb));
        check("read_pointer",  64'(read_pointer),  64'(m_drain ? m_idx : 0));
        check("rd_valid",      64'(rd_valid),      64'(e_rdv));
        check("drain_done",    64'(drain_done),    64'(e_done));
        check("count",         64'(count),         64'(m_cnt));
        check("full",          64'(full),          64'(m_cnt == DEPTH));
        check("busy",          64'(busy),          64'(m_drain));
        new_data();
    endtask

    task automatic load_n(input logic [1:0] v, input int n);
        req_valid = v;
        repeat (n) cycle();
        req_valid = 2'b00;
    endtask

    task automatic drain_all();
        int k;
        drain_start = 1'b1;
        cycle();
        drain_start = 1'b0;
        rd_ready    = 1'b1;
        k = 0;
        while (busy && k < 40) begin
            cycle();
            k++;
        end
        check("drain_timeout", 64'(busy), 64'(0));
        rd_ready = 1'b0;
    endtask

    initial begin
        reset_n     = 1'b0;
        req_valid   = 2'b11;
        drain_start = 1'b0;
        rd_ready    = 1'b0;
        new_data();

        // Reset held with both requesters asserting
        repeat (2) cycle();
        reset_n = 1'b1;

        // Round-robin: 0,1,0,1
        load_n(2'b11, 4);
        check("rr_count", 64'(count), 64'(4));
        drain_all();

        // Fill to full from requester 1; the 33rd request stalls
        load_n(2'b10, 33);
        check("fill_full",  64'(full),  64'(1));
        check("fill_count", 64'(count), 64'(DEPTH));
        drain_all();

        // Drain with backpressure: rd_ready 1,0,1,1
        load_n(2'b01, 3);
        drain_start = 1'b1;
        cycle();
        drain_start = 1'b0;
        rd_ready = 1'b1; cycle();
        rd_ready = 1'b0; cycle();
        rd_ready = 1'b1; cycle();
        rd_ready = 1'b1; cycle();
        rd_ready = 1'b0;
        check("bp_count", 64'(count), 64'(0));
        load_n(2'b01, 1);
        check("bp_reload_addr", 64'(write_pointer), 64'(0));

        // drain_start collides with requests
        load_n(2'b01, 1);
        req_valid   = 2'b11;
        drain_start = 1'b1;
        cycle();
        check("collide_busy", 64'(busy), 64'(1));
        req_valid   = 2'b00;
        drain_start = 1'b0;
        rd_ready    = 1'b1;
        repeat (3) cycle();
        rd_ready    = 1'b0;

        // drain_start with nothing loaded is ignored
        drain_start = 1'b1;
        cycle();
        drain_start = 1'b0;
        cycle();

        // Reset in the middle of a drain
        load_n(2'b11, 8);
        drain_start = 1'b1;
        cycle();
        drain_start = 1'b0;
        rd_ready = 1'b1;
        repeat (5) cycle();
        check("middrain_rp", 64'(read_pointer), 64'(5));
        reset_n = 1'b0;
        cycle();
        reset_n  = 1'b1;
        rd_ready = 1'b0;
        cycle();

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            reset_n     = ($urandom_range(0, 199) != 0);
            drain_start = ($urandom_range(0, 15) == 0);
            rd_ready    = 1'($urandom);
            req_valid   = 2'($urandom);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
